uart_tx_prog: RTL and testbench

//  Buffered 8N1 UART transmitter with a run-time programmable bit period. It is the

---
 rtl/uart_tx_prog.sv | 174 +++++++++++++++++
 tb/tb_uart_tx_prog.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_prog.sv
// Buffered 8N1 UART transmitter: byte FIFO feeding a serialiser whose bit period
// is latched from clks_per_bit_i at the start of every frame.
module uart_tx_prog #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [15:0]                   clks_per_bit_i,
    input  logic                          tx_valid_i,
    input  logic [7:0]                    tx_byte_i,
    output logic                          tx_ready_o,
    output logic                          tx_serial_o,
    output logic                          tx_en_o,
    output logic                          tx_done_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = AW + 1;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StStart = 2'd1;
    localparam logic [1:0] StData  = 2'd2;
    localparam logic [1:0] StStop  = 2'd3;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LW-1:0] level_q;
    logic          push, pop, fifo_empty;

    logic [1:0]  state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic [15:0] period_q, period_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        serial_q, serial_d;
    logic        en_q, en_d;
    logic        done_q, done_d;
    logic        tick;

    // Ready is a pure function of the registered level, so a full FIFO never
    // accepts a byte even on a cycle where the serialiser pops.
    assign tx_ready_o   = level_q < LW'(FIFO_DEPTH);
    assign push         = tx_valid_i & tx_ready_o;
    assign fifo_empty   = (level_q == '0);
    assign fifo_level_o = level_q;

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= tx_byte_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (push && !pop) begin
                level_q <= level_q + LW'(1);
            end else if (!push && pop) begin
                level_q <= level_q - LW'(1);
            end
        end
    end

    assign tick = (timer_q == period_q - 16'd1);

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        period_d  = period_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        serial_d  = serial_q;
        en_d      = en_q;
        done_d    = 1'b0;
        pop       = 1'b0;

        if (state_q != StIdle) begin
            timer_d = tick ? 16'd0 : timer_q + 16'd1;
        end

        case (state_q)
            StIdle: begin
                serial_d = 1'b1;
                en_d     = 1'b0;
                pop      = !fifo_empty;
            end
            StStart: begin
                if (tick) begin
                    state_d   = StData;
                    bit_idx_d = 3'd0;
                    serial_d  = shift_q[0];
                end
            end
            StData: begin
                if (tick) begin
                    if (bit_idx_q == 3'd7) begin
                        state_d   = StStop;
                        bit_idx_d = 3'd0;
                        serial_d  = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                        serial_d  = shift_q[1];
                    end
                end
            end
            StStop: begin
                if (tick) begin
                    if (bit_idx_q == 3'(STOP_BITS - 1)) begin
                        done_d = 1'b1;
                        if (!fifo_empty) begin
                            pop = 1'b1;
                        end else begin
                            state_d  = StIdle;
                            serial_d = 1'b1;
                            en_d     = 1'b0;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Frame load from idle or straight out of the last stop bit (no gap).
        if (pop) begin
            state_d  = StStart;
            shift_d  = mem_q[rd_ptr_q];
            period_d = (clks_per_bit_i < 16'd2) ? 16'd2 : clks_per_bit_i;
            timer_d  = 16'd0;
            serial_d = 1'b0;
            en_d     = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            timer_q   <= 16'd0;
            period_q  <= 16'd2;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'd0;
            serial_q  <= 1'b1;
            en_q      <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            period_q  <= period_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            serial_q  <= serial_d;
            en_q      <= en_d;
            done_q    <= done_d;
        end
    end

    assign tx_serial_o = serial_q;
    assign tx_en_o     = en_q;
    assign tx_done_o   = done_q;

endmodule

// File: tb/tb_uart_tx_prog.sv
// Directed bench for uart_tx_prog: table of single frames plus stream, period
// change, abort and two-stop-bit sequences.
module tb_uart_tx_prog;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] clks_per_bit;
    logic        tx_valid, tx_valid2;
    logic [7:0]  tx_byte;
    logic        tx_ready, tx_serial, tx_en, tx_done;
    logic [2:0]  fifo_level;
    logic        tx_ready2, tx_serial2, tx_en2, tx_done2;
    logic [2:0]  fifo_level2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_tx_prog #(.FIFO_DEPTH(4), .STOP_BITS(1)) dut (
        .clk_i(clk), .rst_i(rst), .clks_per_bit_i(clks_per_bit),
        .tx_valid_i(tx_valid), .tx_byte_i(tx_byte), .tx_ready_o(tx_ready),
        .tx_serial_o(tx_serial), .tx_en_o(tx_en), .tx_done_o(tx_done),
        .fifo_level_o(fifo_level)
    );

    uart_tx_prog #(.FIFO_DEPTH(4), .STOP_BITS(2)) dut2 (
        .clk_i(clk), .rst_i(rst), .clks_per_bit_i(clks_per_bit),
        .tx_valid_i(tx_valid2), .tx_byte_i(tx_byte), .tx_ready_o(tx_ready2),
        .tx_serial_o(tx_serial2), .tx_en_o(tx_en2), .tx_done_o(tx_done2),
        .fifo_level_o(fifo_level2)
    );

    typedef struct {
        logic [15:0] p;
        logic [7:0]  data;
        int unsigned eff_p;
        logic [9:0]  pat;   // line pattern, bit 0 = start bit
        string       name;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called just after the frame's start edge; returns just after its done edge.
    task automatic check_frame(input int unsigned p, input logic [9:0] pat,
                               input bit chained, input string name);
        for (int c = 0; c < 10 * int'(p); c++) begin
            @(negedge clk);
            chk({name, " line"}, 32'(tx_serial), 32'(pat[c / int'(p)]));
            chk({name, " en"}, 32'(tx_en), 32'd1);
            chk({name, " done"}, 32'(tx_done), 32'((c == 0) && chained));
            @(posedge clk);
        end
    endtask

    task automatic send_one(input logic [15:0] p, input logic [7:0] b);
        @(negedge clk);
        clks_per_bit = p;
        tx_valid     = 1'b1;
        tx_byte      = b;
        @(posedge clk);
        #1 tx_valid = 1'b0;
        chk("level after push", 32'(fifo_level), 32'd1);
        @(negedge clk);
        chk("latency line still idle", 32'(tx_serial), 32'd1);
        @(posedge clk);
    endtask

    task automatic end_idle(input string name);
        @(negedge clk);
        chk({name, " done pulse"}, 32'(tx_done), 32'd1);
        chk({name, " en low"}, 32'(tx_en), 32'd0);
        chk({name, " line idle"}, 32'(tx_serial), 32'd1);
        @(negedge clk);
        chk({name, " done one cycle"}, 32'(tx_done), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] sb [6];
        logic [9:0] spat [6];
        logic [10:0] pat2;
        int wait_cnt;
        int bad;

        vecs[0] = '{16'd4, 8'hA5, 4, 10'b1101001010, "a5_p4"};
        vecs[1] = '{16'd0, 8'h01, 2, 10'b1000000010, "01_p0clamp"};
        vecs[2] = '{16'd1, 8'hFF, 2, 10'b1111111110, "ff_p1clamp"};
        vecs[3] = '{16'd3, 8'h00, 3, 10'b1000000000, "00_p3"};
        vecs[4] = '{16'd5, 8'h3C, 5, 10'b1001111000, "3c_p5"};

        rst = 1'b1; clks_per_bit = 16'd4; tx_valid = 1'b0; tx_valid2 = 1'b0; tx_byte = 8'h00;
        #3;
        chk("reset line", 32'(tx_serial), 32'd1);
        chk("reset en", 32'(tx_en), 32'd0);
        chk("reset done", 32'(tx_done), 32'd0);
        chk("reset ready", 32'(tx_ready), 32'd1);
        chk("reset level", 32'(fifo_level), 32'd0);
        chk("reset2 ready", 32'(tx_ready2), 32'd1);
        chk("reset2 level", 32'(fifo_level2), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            send_one(vecs[i].p, vecs[i].data);
            check_frame(vecs[i].eff_p, vecs[i].pat, 1'b0, vecs[i].name);
            end_idle(vecs[i].name);
        end

        // Stream of six bytes at P=2 into a 4-deep FIFO.
        sb   = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        spat = '{10'b1000100010, 10'b1001000100, 10'b1001100110,
                 10'b1010001000, 10'b1010101010, 10'b1011001100};
        clks_per_bit = 16'd2;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    @(negedge clk);
                    tx_valid = 1'b1;
                    tx_byte  = sb[i];
                    wait_cnt = 0;
                    if (i == 5) chk("sixth byte ready low", 32'(tx_ready), 32'd0);
                    while (!tx_ready && wait_cnt < 100) begin
                        @(negedge clk);
                        wait_cnt++;
                    end
                    if (i == 5) begin
                        chk("ready low cycles", 32'(wait_cnt), 32'd17);
                        chk("ready returns with done", 32'(tx_done), 32'd1);
                    end
                    @(posedge clk);
                    #1;
                end
                tx_valid = 1'b0;
            end
            begin
                @(negedge clk);
                @(posedge clk);
                @(posedge clk);
                for (int f = 0; f < 6; f++) begin
                    check_frame(2, spat[f], f > 0, $sformatf("stream%0d", f));
                end
                end_idle("stream end");
            end
        join

        // P change during DATA bit 2 affects only the next queued frame.
        @(negedge clk);
        clks_per_bit = 16'd8;
        tx_valid = 1'b1;
        tx_byte  = 8'h5A;
        @(posedge clk);
        #1 tx_byte = 8'hC3;
        @(posedge clk);
        #1 tx_valid = 1'b0;
        fork
            begin
                check_frame(8, 10'b1010110100, 1'b0, "pchg first");
                check_frame(3, 10'b1110000110, 1'b1, "pchg second");
                end_idle("pchg");
            end
            begin
                repeat (27) @(posedge clk);
                #1 clks_per_bit = 16'd3;
            end
        join

        // Abort mid-frame with two bytes queued.
        @(negedge clk);
        clks_per_bit = 16'd4;
        tx_valid = 1'b1;
        tx_byte  = 8'h12;
        @(posedge clk);
        #1 tx_byte = 8'h34;
        @(posedge clk);
        #1 tx_byte = 8'h56;
        @(posedge clk);
        #1 tx_valid = 1'b0;
        repeat (16) @(posedge clk);
        #1;
        chk("pre-abort level", 32'(fifo_level), 32'd2);
        chk("pre-abort line bit3", 32'(tx_serial), 32'd0);
        #1 rst = 1'b1;
        #1;
        chk("abort line", 32'(tx_serial), 32'd1);
        chk("abort en", 32'(tx_en), 32'd0);
        chk("abort done", 32'(tx_done), 32'd0);
        chk("abort level", 32'(fifo_level), 32'd0);
        chk("abort ready", 32'(tx_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (tx_serial !== 1'b1 || tx_en !== 1'b0 || tx_done !== 1'b0) bad++;
        end
        chk("post-abort quiet cycles", 32'(bad), 32'd0);
        send_one(16'd4, 8'h3C);
        check_frame(4, 10'b1001111000, 1'b0, "post-abort 3c");
        end_idle("post-abort");

        // Two stop bits: frame is 11*P.
        pat2 = 11'b11010101010;
        @(negedge clk);
        clks_per_bit = 16'd2;
        tx_valid2 = 1'b1;
        tx_byte   = 8'h55;
        @(posedge clk);
        #1 tx_valid2 = 1'b0;
        @(posedge clk);
        for (int c = 0; c < 22; c++) begin
            @(negedge clk);
            chk("stop2 line", 32'(tx_serial2), 32'(pat2[c / 2]));
            chk("stop2 en", 32'(tx_en2), 32'd1);
            chk("stop2 done", 32'(tx_done2), 32'd0);
            @(posedge clk);
        end
        @(negedge clk);
        chk("stop2 done pulse", 32'(tx_done2), 32'd1);
        chk("stop2 en low", 32'(tx_en2), 32'd0);
        chk("stop2 level", 32'(fifo_level2), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
